// File: rtl/register_arbiter.sv
// Round-robin arbiter that loads one pending requester's data per cycle into a
// shared register and returns a one-cycle ack to the winner.
module register_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    localparam int unsigned OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   in,
    output logic [NUM_REQ-1:0]              ack,
    output logic [WIDTH-1:0]                out,
    output logic [OW-1:0]                   owner,
    output logic                            valid
);

    logic [OW-1:0]      ptr;
    logic [NUM_REQ-1:0] elig;
    logic [OW-1:0]      win;
    logic               found;
    logic [OW:0]        idx;

    // A requester acked this cycle is masked so it cannot be loaded twice.
    assign elig = req & ~ack;

    // Scan from ptr upward with wraparound; first eligible requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (OW+1)'(k);
            if (idx >= (OW+1)'(NUM_REQ)) begin
                idx = idx - (OW+1)'(NUM_REQ);
            end
            if (!found && elig[idx[OW-1:0]]) begin
                found = 1'b1;
                win   = idx[OW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            ack   <= '0;
            owner <= '0;
            valid <= 1'b0;
            ptr   <= '0;
        end else if (found) begin
            out   <= in[win];
            ack   <= NUM_REQ'(1) << win;
            owner <= win;
            valid <= 1'b1;
            ptr   <= (win == OW'(NUM_REQ - 1)) ? '0 : win + OW'(1);
        end else begin
            ack   <= '0;
        end
    end

endmodule
